// File: rtl/tone_frame_packer_pkg.sv
// ============================================================================
// Module : tone_frame_packer_pkg
// Brief  : Shared constants, field layout, FSM encoding and tuser slicing for
//          the tone frame packer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package tone_frame_packer_pkg;

   localparam logic [15:0] C_MAGIC_DEFAULT = 16'hF5E1;

   localparam int C_DATA_FIFO_W = 129;   // {last, 128b word}
   localparam int C_HDR_FIFO_W  = 96;    // header word without the low pad
   localparam int C_NBEATS_W    = 10;
   localparam int C_TS_W        = 32;
   localparam int C_IDX_W       = 7;
   localparam int C_K_W         = 14;
   localparam int C_DATA_PAD_W  = 27;
   localparam int C_HDR_PAD_W   = 32;

   localparam int C_HDR_FCNT_LSB = 64;   // frame_cnt position inside the header FIFO word

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_DATA = 2'd2
`ifdef TONE_FRAME_PACKER_TRAILER_EN
      ,
      ST_TRL  = 2'd3
`endif
   } out_state_t;

   function automatic logic [C_TS_W-1:0] tuser_ts(input logic [52:0] u);
      return u[52:21];
   endfunction

   function automatic logic [C_IDX_W-1:0] tuser_idx(input logic [52:0] u);
      return u[20:14];
   endfunction

   function automatic logic [C_K_W-1:0] tuser_k(input logic [52:0] u);
      return u[13:0];
   endfunction

endpackage

`default_nettype wire

// File: rtl/tone_frame_packer_fifo.sv
// ============================================================================
// Module : sync_fifo
// Brief  : Single-clock show-ahead FIFO with occupancy count.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_wr_en,
   input  logic [WIDTH-1:0]         i_wr_data,
   input  logic                     i_rd_en,
   output logic [WIDTH-1:0]         o_rd_data,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full,
   output logic                     o_empty
);

   localparam int                C_AW    = $clog2(DEPTH);
   localparam logic [C_AW:0]     C_DEPTH = (C_AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [C_AW:0]    r_wr_ptr;
   logic [C_AW:0]    r_rd_ptr;
   logic             w_wr;
   logic             w_rd;

   assign w_wr = i_wr_en && !o_full;
   assign w_rd = i_rd_en && !o_empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr[C_AW-1:0]] <= i_wr_data;
   end

   assign o_count   = r_wr_ptr - r_rd_ptr;
   assign o_full    = (o_count == C_DEPTH);
   assign o_empty   = (o_count == '0);
   assign o_rd_data = r_mem[r_rd_ptr[C_AW-1:0]];

endmodule

`default_nettype wire

// File: rtl/tone_frame_packer.sv
// ============================================================================
// Module : tone_frame_packer
// Brief  : Packs tone frames into header + data AXI-stream packets, dropping
//          whole frames when buffering is short. Optional trailer beat via
//          TONE_FRAME_PACKER_TRAILER_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tone_frame_packer
   import tone_frame_packer_pkg::*;
#(
   parameter int          DATA_FIFO_DEPTH = 512,
   parameter int          HDR_FIFO_DEPTH  = 16,
   parameter int          MAX_BEATS       = 128,
   parameter logic [15:0] MAGIC           = C_MAGIC_DEFAULT
) (
   input  logic          dev_clk,
   input  logic          dev_rst,
   input  logic [79:0]   s_axis_tdata,
   input  logic [52:0]   s_axis_tuser,
   input  logic          s_axis_tvalid,
   input  logic          s_axis_tlast,
   input  logic          en,
   output logic [127:0]  m_axis_tdata,
   output logic          m_axis_tvalid,
   input  logic          m_axis_tready,
   output logic          m_axis_tlast,
   output logic [15:0]   frame_count,
   output logic [31:0]   drop_count
);

   localparam int                    C_DCW        = $clog2(DATA_FIFO_DEPTH) + 1;
   localparam int                    C_HCW        = $clog2(HDR_FIFO_DEPTH) + 1;
   localparam logic [C_DCW-1:0]      C_DATA_LIMIT = C_DCW'(DATA_FIFO_DEPTH - MAX_BEATS);
   localparam logic [C_HCW-1:0]      C_HDR_ALMOST = C_HCW'(HDR_FIFO_DEPTH - 1);
   localparam logic [C_NBEATS_W-1:0] C_MAX_V      = C_NBEATS_W'(MAX_BEATS);

   // input side state
   logic                     r_in_frame;
   logic                     r_accept;
   logic                     r_trunc;
   logic [C_NBEATS_W-1:0]    r_nbeats;
   logic [C_TS_W-1:0]        r_ts;
   logic [C_K_W-1:0]         r_k;
   logic [C_IDX_W-1:0]       r_idx;
   logic [15:0]              r_fcnt_snap;
   logic [15:0]              r_frame_count;
   logic [31:0]              r_drop_count;
   logic                     r_hdr_push;

   logic [C_DATA_FIFO_W-1:0] w_data_wdata;
   logic [C_DATA_FIFO_W-1:0] w_data_rdata;
   logic [C_DCW-1:0]         w_data_cnt;
   logic                     w_data_full;
   logic                     w_data_empty;
   logic [C_HDR_FIFO_W-1:0]  w_hdr_wdata;
   logic [C_HDR_FIFO_W-1:0]  w_hdr_rdata;
   logic [C_HCW-1:0]         w_hdr_cnt;
   logic                     w_hdr_full;
   logic                     w_hdr_empty;

   logic                     w_start;
   logic                     w_short;
   logic                     w_accept_start;
   logic                     w_drop_start;
   logic                     w_beat_ok;
   logic                     w_data_wr;
   logic [C_NBEATS_W-1:0]    w_next_n;
   logic                     w_data_last;
   logic                     w_close;

   // A header closed last cycle is not yet counted by the FIFO but already owns a slot.
   assign w_start        = s_axis_tvalid && !r_in_frame;
   assign w_short        = w_data_full || (w_data_cnt > C_DATA_LIMIT) || w_hdr_full ||
                           (r_hdr_push && (w_hdr_cnt == C_HDR_ALMOST));
   assign w_accept_start = w_start && en && !w_short;
   assign w_drop_start   = w_start && en && w_short;
   assign w_beat_ok      = (r_nbeats < C_MAX_V);
   assign w_data_wr      = w_accept_start || (s_axis_tvalid && r_in_frame && r_accept && w_beat_ok);
   assign w_next_n       = w_accept_start ? C_NBEATS_W'(1) : r_nbeats + 1'b1;
   assign w_data_last    = s_axis_tlast || (w_next_n == C_MAX_V);
   assign w_close        = s_axis_tvalid && s_axis_tlast && (w_accept_start || (r_in_frame && r_accept));

   assign w_data_wdata = {w_data_last, tuser_idx(s_axis_tuser), tuser_k(s_axis_tuser),
                          {C_DATA_PAD_W{1'b0}}, s_axis_tdata};
   assign w_hdr_wdata  = {MAGIC, r_fcnt_snap, r_ts, r_k, r_idx, r_trunc, r_nbeats};

   always_ff @(posedge dev_clk) begin
      if (dev_rst) begin
         r_in_frame    <= 1'b0;
         r_accept      <= 1'b0;
         r_trunc       <= 1'b0;
         r_nbeats      <= '0;
         r_ts          <= '0;
         r_k           <= '0;
         r_idx         <= '0;
         r_fcnt_snap   <= '0;
         r_frame_count <= '0;
         r_drop_count  <= '0;
         r_hdr_push    <= 1'b0;
      end else begin
         r_hdr_push <= w_close;
         if (s_axis_tvalid) begin
            if (!r_in_frame) begin
               r_in_frame <= !s_axis_tlast;
               r_accept   <= w_accept_start;
               if (en) r_frame_count <= r_frame_count + 1'b1;
               if (w_drop_start && (r_drop_count != 32'hFFFF_FFFF)) r_drop_count <= r_drop_count + 1'b1;
               if (w_accept_start) begin
                  r_ts        <= tuser_ts(s_axis_tuser);
                  r_k         <= tuser_k(s_axis_tuser);
                  r_idx       <= tuser_idx(s_axis_tuser);
                  r_fcnt_snap <= r_frame_count;
                  r_nbeats    <= C_NBEATS_W'(1);
                  r_trunc     <= 1'b0;
               end
            end else begin
               if (s_axis_tlast) r_in_frame <= 1'b0;
               if (r_accept) begin
                  if (w_beat_ok) r_nbeats <= w_next_n;
                  else           r_trunc  <= 1'b1;
               end
            end
         end
      end
   end

   // output side
   out_state_t r_state;
   out_state_t w_next;
   logic       w_can_load;
   logic       w_hdr_pop;
   logic       w_data_pop;
   logic       w_trl_load;
   logic       r_tvalid;
   logic       r_tlast;
   logic [127:0] r_tdata;

   assign w_can_load = !r_tvalid || m_axis_tready;

   always_ff @(posedge dev_clk) begin
      if (dev_rst) r_state <= ST_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_hdr_pop  = 1'b0;
      w_data_pop = 1'b0;
      w_trl_load = 1'b0;
      case (r_state)
         ST_IDLE: if (!w_hdr_empty) w_next = ST_HDR;
         ST_HDR: begin
            if (w_can_load) begin
               w_hdr_pop = 1'b1;
               w_next    = ST_DATA;
            end
         end
         ST_DATA: begin
            if (w_can_load && !w_data_empty) begin
               w_data_pop = 1'b1;
`ifdef TONE_FRAME_PACKER_TRAILER_EN
               if (w_data_rdata[128]) w_next = ST_TRL;
`else
               if (w_data_rdata[128]) w_next = ST_IDLE;
`endif
            end
         end
`ifdef TONE_FRAME_PACKER_TRAILER_EN
         ST_TRL: begin
            if (w_can_load) begin
               w_trl_load = 1'b1;
               w_next     = ST_IDLE;
            end
         end
`endif
         default: w_next = ST_IDLE;
      endcase
   end

`ifdef TONE_FRAME_PACKER_TRAILER_EN
   logic [31:0] r_xor;
   logic [15:0] r_pkt_fcnt;

   always_ff @(posedge dev_clk) begin
      if (dev_rst) begin
         r_xor      <= '0;
         r_pkt_fcnt <= '0;
      end else if (w_hdr_pop) begin
         r_xor      <= '0;
         r_pkt_fcnt <= w_hdr_rdata[C_HDR_FCNT_LSB +: 16];
      end else if (w_data_pop) begin
         r_xor <= r_xor ^ w_data_rdata[127:96] ^ w_data_rdata[95:64] ^
                  w_data_rdata[63:32] ^ w_data_rdata[31:0];
      end
   end
`endif

   // The output register only reloads when empty or being consumed, so it holds under backpressure.
   always_ff @(posedge dev_clk) begin
      if (dev_rst) begin
         r_tvalid <= 1'b0;
         r_tlast  <= 1'b0;
         r_tdata  <= '0;
      end else if (w_hdr_pop) begin
         r_tvalid <= 1'b1;
         r_tlast  <= 1'b0;
         r_tdata  <= {w_hdr_rdata, {C_HDR_PAD_W{1'b0}}};
      end else if (w_data_pop) begin
         r_tvalid <= 1'b1;
`ifdef TONE_FRAME_PACKER_TRAILER_EN
         r_tlast  <= 1'b0;
`else
         r_tlast  <= w_data_rdata[128];
`endif
         r_tdata  <= w_data_rdata[127:0];
`ifdef TONE_FRAME_PACKER_TRAILER_EN
      end else if (w_trl_load) begin
         r_tvalid <= 1'b1;
         r_tlast  <= 1'b1;
         r_tdata  <= {MAGIC, r_pkt_fcnt, 64'h0, r_xor};
`endif
      end else if (m_axis_tready) begin
         r_tvalid <= 1'b0;
      end
   end

   sync_fifo #(
      .DEPTH (DATA_FIFO_DEPTH),
      .WIDTH (C_DATA_FIFO_W)
   ) u_data_fifo (
      .clk       (dev_clk),
      .rst       (dev_rst),
      .i_wr_en   (w_data_wr),
      .i_wr_data (w_data_wdata),
      .i_rd_en   (w_data_pop),
      .o_rd_data (w_data_rdata),
      .o_count   (w_data_cnt),
      .o_full    (w_data_full),
      .o_empty   (w_data_empty)
   );

   sync_fifo #(
      .DEPTH (HDR_FIFO_DEPTH),
      .WIDTH (C_HDR_FIFO_W)
   ) u_hdr_fifo (
      .clk       (dev_clk),
      .rst       (dev_rst),
      .i_wr_en   (r_hdr_push),
      .i_wr_data (w_hdr_wdata),
      .i_rd_en   (w_hdr_pop),
      .o_rd_data (w_hdr_rdata),
      .o_count   (w_hdr_cnt),
      .o_full    (w_hdr_full),
      .o_empty   (w_hdr_empty)
   );

   assign m_axis_tdata  = r_tdata;
   assign m_axis_tvalid = r_tvalid;
   assign m_axis_tlast  = r_tlast;
   assign frame_count   = r_frame_count;
   assign drop_count    = r_drop_count;

endmodule

`default_nettype wire

// File: tb/tb_tone_frame_packer.sv
// ============================================================================
// Module : tb_tone_frame_packer
// Brief  : Scoreboard bench for tone_frame_packer with a frame-level model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tone_frame_packer;

   localparam int          P_DDEPTH = 16;
   localparam int          P_HDEPTH = 4;
   localparam int          P_MAX    = 8;
   localparam logic [15:0] P_MAGIC  = 16'hF5E1;

   logic         clk = 1'b0;
   logic         rst;
   logic [79:0]  s_tdata;
   logic [52:0]  s_tuser;
   logic         s_tvalid;
   logic         s_tlast;
   logic         s_en;
   logic [127:0] m_tdata;
   logic         m_tvalid;
   logic         m_tready;
   logic         m_tlast;
   logic [15:0]  frame_count;
   logic [31:0]  drop_count;

   always #5 clk = ~clk;

   tone_frame_packer #(
      .DATA_FIFO_DEPTH (P_DDEPTH),
      .HDR_FIFO_DEPTH  (P_HDEPTH),
      .MAX_BEATS       (P_MAX),
      .MAGIC           (P_MAGIC)
   ) dut (
      .dev_clk       (clk),
      .dev_rst       (rst),
      .s_axis_tdata  (s_tdata),
      .s_axis_tuser  (s_tuser),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tlast  (s_tlast),
      .en            (s_en),
      .m_axis_tdata  (m_tdata),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tready (m_tready),
      .m_axis_tlast  (m_tlast),
      .frame_count   (frame_count),
      .drop_count    (drop_count)
   );

   typedef struct {
      logic [127:0] d;
      logic         l;
      int           kind;   // 0 header, 1 data, 2 trailer
   } exp_t;

   exp_t        exp_q[$];
   int          n_cmp = 0;
   int          n_err = 0;
   logic [15:0] m_fcnt = '0;
   logic [31:0] m_drop = '0;
   int          rdy_mode = 0;   // 0 low, 1 high, 2 random
   bit          mon_off = 1'b1;

   task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int pend(input int kind);
      int n = 0;
      foreach (exp_q[i]) if (exp_q[i].kind == kind) n++;
      return n;
   endfunction

   initial begin
      m_tready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       m_tready = 1'b0;
            1:       m_tready = 1'b1;
            default: m_tready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // monitor: pops the scoreboard on every handshake and checks hold under stall
   bit           stall = 1'b0;
   logic [127:0] p_data;
   logic         p_last;
   always @(negedge clk) begin
      exp_t e;
      if (mon_off) begin
         stall = 1'b0;
      end else begin
         if (stall) chk("hold", {m_tvalid, m_tlast, m_tdata}, {1'b1, p_last, p_data});
         stall  = m_tvalid && !m_tready;
         p_data = m_tdata;
         p_last = m_tlast;
         if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_beat: got %0h expected none", m_tdata);
            end else begin
               e = exp_q.pop_front();
               chk(e.kind == 0 ? "header" : (e.kind == 1 ? "data" : "trailer"),
                   {m_tlast, m_tdata}, {e.l, e.d});
            end
         end
      end
   end

   // Model decision is made at frame start from what is still buffered; frames are
   // only sent back-to-back where nothing can drain in between.
   task automatic send_frame(input int nb, input bit en0, input int max_gap,
                             input logic [31:0] ts, input logic [13:0] k, input logic [6:0] idx0);
      logic [79:0] td[$];
      logic [6:0]  idx;
      logic [31:0] x;
      int          nd;
      int          g;
      bit          drop;
      for (int i = 0; i < nb; i++) td.push_back({16'($urandom), $urandom, $urandom});
      nd = (nb < P_MAX) ? nb : P_MAX;
      if (en0) begin
         drop = (pend(1) > P_DDEPTH - P_MAX) || (pend(0) - 1 >= P_HDEPTH);
         if (drop) begin
            m_drop++;
         end else begin
            exp_q.push_back('{{P_MAGIC, m_fcnt, ts, k, idx0, (nb > P_MAX), 10'(nd), 32'h0}, 1'b0, 0});
            x = '0;
            for (int i = 0; i < nd; i++) begin
               logic [127:0] w;
               idx = idx0 + 7'(i);
               w   = {idx, k, 27'h0, td[i]};
               x   = x ^ w[127:96] ^ w[95:64] ^ w[63:32] ^ w[31:0];
`ifdef TONE_FRAME_PACKER_TRAILER_EN
               exp_q.push_back('{w, 1'b0, 1});
`else
               exp_q.push_back('{w, (i == nd - 1), 1});
`endif
            end
`ifdef TONE_FRAME_PACKER_TRAILER_EN
            exp_q.push_back('{{P_MAGIC, m_fcnt, 64'h0, x}, 1'b1, 2});
`endif
         end
         m_fcnt++;
      end
      for (int i = 0; i < nb; i++) begin
         g = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
         repeat (g) begin
            s_tvalid = 1'b0;
            tick();
         end
         idx      = idx0 + 7'(i);
         s_tvalid = 1'b1;
         s_tlast  = (i == nb - 1);
         s_tdata  = td[i];
         s_tuser  = {ts, idx, k};
         s_en     = (i == 0 || max_gap == 0) ? en0 : 1'($urandom);
         tick();
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic wait_q(input int target, input int budget);
      int c = 0;
      while (exp_q.size() > target && c < budget) begin
         tick();
         c++;
      end
      if (exp_q.size() > target) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain_timeout: got %0d pending expected %0d", exp_q.size(), target);
      end
   endtask

   task automatic check_counts(input string nm);
      chk({nm, "_frame_count"}, 160'(frame_count), 160'(m_fcnt));
      chk({nm, "_drop_count"}, 160'(drop_count), 160'(m_drop));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; s_tdata = '0; s_tuser = '0; s_tvalid = 1'b0; s_tlast = 1'b0; s_en = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      chk("reset_outputs", {m_tvalid, m_tlast, m_tdata}, 130'h0);
      check_counts("reset");
      mon_off = 1'b0;

      // basic 4-beat frame
      rdy_mode = 1;
      send_frame(4, 1'b1, 0, 32'h1234, 14'd5, 7'd0);
      wait_q(0, 200);
      check_counts("basic");

      // stall on data beat 2
      rdy_mode = 0;
      send_frame(4, 1'b1, 0, 32'hABCD_0001, 14'd77, 7'd10);
      repeat (5) tick();
      rdy_mode = 1;
      wait_q(3, 100);
      rdy_mode = 0;
      repeat (10) tick();
      rdy_mode = 1;
      wait_q(0, 200);

      // truncation followed immediately by a short frame
      send_frame(12, 1'b1, 0, 32'h5555_0000, 14'h3FFF, 7'd120);
      send_frame(2, 1'b1, 0, 32'h0000_AAAA, 14'd1, 7'd3);
      wait_q(0, 300);
      check_counts("trunc");

      // data FIFO short: third frame dropped
      rdy_mode = 0;
      for (int f = 0; f < 3; f++) begin
         send_frame(8, 1'b1, 0, $urandom, 14'($urandom), 7'($urandom));
         repeat (5) tick();
      end
      check_counts("data_drop");
      rdy_mode = 1;
      wait_q(0, 400);

      // header FIFO full: sixth single-beat frame dropped
      rdy_mode = 0;
      for (int f = 0; f < 6; f++) begin
         send_frame(1, 1'b1, 0, $urandom, 14'($urandom), 7'($urandom));
         repeat (5) tick();
      end
      check_counts("hdr_drop");
      rdy_mode = 1;
      wait_q(0, 400);

      // single-beat frame and a disabled frame
      send_frame(1, 1'b1, 0, 32'hCAFE_F00D, 14'd9, 7'd42);
      wait_q(0, 100);
      send_frame(5, 1'b0, 0, 32'hDEAD_BEEF, 14'd8, 7'd0);
      repeat (10) tick();
      check_counts("en_off");

      // randomized frames with random backpressure and input gaps
      rdy_mode = 2;
      for (int f = 0; f < 40; f++) begin
         send_frame($urandom_range(1, 12), ($urandom_range(0, 4) != 0), $urandom_range(0, 2),
                    $urandom, 14'($urandom), 7'($urandom));
         wait_q(0, 600);
         repeat ($urandom_range(0, 3)) tick();
      end
      check_counts("random");

      // reset in the middle of a packet's data beats
      rdy_mode = 1;
      send_frame(6, 1'b1, 0, 32'h6666_6666, 14'd6, 7'd6);
      wait_q(5, 100);
      mon_off = 1'b1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_mid_tvalid", 160'(m_tvalid), 160'(0));
      exp_q.delete();
      m_fcnt = '0;
      m_drop = '0;
      check_counts("rst_mid");
      repeat (3) tick();
      mon_off = 1'b0;
      send_frame(3, 1'b1, 0, 32'h7777_0000, 14'd7, 7'd0);
      wait_q(0, 200);
      check_counts("after_rst");
      repeat (5) tick();
      chk("leftover", 160'(exp_q.size()), 160'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
